mem_stage_lsu: RTL and testbench

//  Parametrised memory-access stage for the pipeline; successor to the fixed 64-bit memory stage.

---
 rtl/mem_stage_lsu_pkg.sv | 21 ++
 rtl/mem_stage_lsu_load_align.sv | 40 ++++
 rtl/mem_stage_lsu.sv | 155 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-access stage: access sizes and the LSU sequencer states.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(msize_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load-data aligner: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them to the register width.
module load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int XLEN   = 64,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [OFF_W-1:0]  off,
  input  msize_t            size,
  input  logic              zext,
  output logic [XLEN-1:0]   result
);

  // Narrow buses never carry an 8-byte load, so clamp the sign-bit index.
  localparam int TOP8 = (DATA_W >= 64) ? 63 : DATA_W - 1;

  logic [DATA_W-1:0] sh;
  logic              sign;
  int                nbits;

  always_comb begin
    sh     = raw >> {off, 3'b000};
    nbits  = 8;
    sign   = 1'b0;
    result = '0;
    unique case (size)
      MSIZE1: begin nbits = 8;  sign = sh[7];    end
      MSIZE2: begin nbits = 16; sign = sh[15];   end
      MSIZE4: begin nbits = 32; sign = sh[31];   end
      MSIZE8: begin nbits = 64; sign = sh[TOP8]; end
    endcase
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? sh[i] : (sign & ~zext);
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: issues one bus request per load/store, holds it until accepted,
// copes with split addr_ok/data_ok handshakes, flags misaligned accesses and aligns loads.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int XLEN   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_load,
  input  logic                in_store,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic                flush,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [1:0]          dreq_size,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data,
  output logic                stall,
  output logic                done,
  output logic [XLEN-1:0]     rdata,
  output logic                misalign
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_t state, state_nxt;

  logic                memop, bad, go, drop_set;
  logic [OFF_W-1:0]    off;
  logic [3:0]          off4;
  logic [3:0]          nbytes;
  logic [15:0]         mask16;
  logic [STRB_W+15:0]  strb_full;
  logic [STRB_W-1:0]   st_strobe;
  logic [DATA_W-1:0]   wd_ext, st_data;

  logic [OFF_W-1:0]    off_q;
  msize_t              size_q;
  logic                uns_q, load_q, drop_q;
  logic [XLEN-1:0]     aligned;

  // Decode the live instruction: alignment check plus store lane placement.
  always_comb begin
    off    = in_addr[OFF_W-1:0];
    off4   = '0;
    off4[OFF_W-1:0] = off;
    nbytes = size_bytes(msize_t'(in_size));
    memop  = in_valid & (in_load | in_store);
    bad    = (|(off4 & (nbytes - 4'd1))) | ({1'b0, nbytes} > 5'(STRB_W));
    go     = memop & ~bad & ~flush;

    mask16    = (16'd1 << nbytes) - 16'd1;
    strb_full = {{STRB_W{1'b0}}, mask16} << off;
    st_strobe = strb_full[STRB_W-1:0];

    wd_ext = '0;
    wd_ext[XLEN-1:0] = in_wdata;
    st_data = wd_ext << {off, 3'b000};
  end

  // Sequencer next state and handshake outputs; a flushed WAIT keeps stalling until data_ok drains it.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    drop_set  = 1'b0;
    unique case (state)
      IDLE: begin
        misalign = memop & bad & ~flush;
        stall    = go;
        if (go) state_nxt = REQ;
      end
      REQ: begin
        if (dresp_addr_ok && dresp_data_ok) begin
          state_nxt = IDLE;
          done      = ~flush;
        end else if (dresp_addr_ok) begin
          state_nxt = WAIT;
          stall     = 1'b1;
          drop_set  = flush;
        end else if (flush) begin
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT: begin
        if (dresp_data_ok) begin
          state_nxt = IDLE;
          done      = ~drop_q & ~flush;
        end else begin
          stall    = 1'b1;
          drop_set = flush;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      off_q       <= '0;
      size_q      <= MSIZE1;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        dreq_valid  <= 1'b1;
        dreq_addr   <= in_addr;
        dreq_size   <= in_size;
        dreq_strobe <= in_store ? st_strobe : '0;
        dreq_data   <= in_store ? st_data : '0;
        off_q       <= off;
        size_q      <= msize_t'(in_size);
        uns_q       <= in_unsigned;
        load_q      <= in_load;
      end else if (state == REQ && (dresp_addr_ok || flush)) begin
        dreq_valid <= 1'b0;
      end
      if (state_nxt == IDLE) drop_q <= 1'b0;
      else if (drop_set)     drop_q <= 1'b1;
    end
  end

  load_align #(.DATA_W(DATA_W), .XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .raw    (dresp_data),
    .off    (off_q),
    .size   (size_q),
    .zext   (uns_q),
    .result (aligned)
  );

  assign rdata = (done && load_q) ? aligned : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: 64-bit bus instance plus a 32-bit bus instance for size rejection.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_load, in_store, in_unsigned, flush;
  logic [63:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  logic        dreq_valid, stall, done, misalign;
  logic [63:0] dreq_addr, dreq_data, rdata;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;

  logic        n_dreq_valid, n_stall, n_done, n_misalign;
  logic [63:0] n_dreq_addr;
  logic [31:0] n_dreq_data, n_rdata;
  logic [1:0]  n_dreq_size;
  logic [3:0]  n_dreq_strobe;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_addr(in_addr), .in_size(in_size), .in_unsigned(in_unsigned), .in_wdata(in_wdata),
    .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .stall(stall), .done(done),
    .rdata(rdata), .misalign(misalign)
  );

  mem_stage_lsu #(.ADDR_W(64), .DATA_W(32), .XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_addr(in_addr), .in_size(in_size), .in_unsigned(in_unsigned), .in_wdata(in_wdata[31:0]),
    .flush(flush), .dreq_valid(n_dreq_valid), .dreq_addr(n_dreq_addr), .dreq_size(n_dreq_size),
    .dreq_strobe(n_dreq_strobe), .dreq_data(n_dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data[31:0]), .stall(n_stall), .done(n_done),
    .rdata(n_rdata), .misalign(n_misalign)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic load, input logic store,
                               input logic [63:0] addr, input logic [1:0] size,
                               input logic uns, input logic [63:0] wdata);
    in_valid    = valid;
    in_load     = load;
    in_store    = store;
    in_addr     = addr;
    in_size     = size;
    in_unsigned = uns;
    in_wdata    = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 2'd0, 1'b0, 64'h0);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    flush         = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    dresp_data = 64'h0;
    idleBus();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_dreq_valid", dreq_valid, 0);
    checkOutput("rst_strobe", dreq_strobe, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_misalign", misalign, 0);

    // SW 0xDEADBEEF @0x1004, granted in first REQ cycle
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h1004, 2'd2, 1'b0, 64'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("sw_c0_stall", stall, 1);
    checkOutput("sw_c0_dreq_valid", dreq_valid, 0);
    nextCycle();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    checkOutput("sw_dreq_valid", dreq_valid, 1);
    checkOutput("sw_addr", dreq_addr, 64'h1004);
    checkOutput("sw_strobe", dreq_strobe, 8'hF0);
    checkOutput("sw_data_hi", dreq_data[63:32], 32'hDEAD_BEEF);
    checkOutput("sw_data_lo", dreq_data[31:0], 32'h0);
    checkOutput("sw_done", done, 1);
    checkOutput("sw_stall", stall, 0);
    nextCycle();
    idleBus();
    @(negedge clk);
    checkOutput("sw_after_valid", dreq_valid, 0);
    checkOutput("sw_after_done", done, 0);

    // LB @0x1003, split handshake
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1003, 2'd0, 1'b0, 64'h0);
    dresp_data = 64'h0000_0000_8000_0000;
    @(negedge clk);
    checkOutput("lb_c0_stall", stall, 1);
    nextCycle();
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("lb_c1_stall", stall, 1);
    checkOutput("lb_c1_done", done, 0);
    checkOutput("lb_c1_strobe", dreq_strobe, 0);
    nextCycle();
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("lb_c2_dreq_valid", dreq_valid, 0);
    checkOutput("lb_c2_stall", stall, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("lb_c3_stall", stall, 1);
    nextCycle();
    dresp_data_ok = 1'b1;
    @(negedge clk);
    checkOutput("lb_c4_done", done, 1);
    checkOutput("lb_c4_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    checkOutput("lb_c4_stall", stall, 0);
    nextCycle();
    idleBus();

    // LHU @0x1006
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1006, 2'd1, 1'b1, 64'h0);
    dresp_data = 64'h8001_1234_5678_9ABC;
    nextCycle();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    checkOutput("lhu_done", done, 1);
    checkOutput("lhu_rdata", rdata, 64'h8001);
    checkOutput("lhu_strobe", dreq_strobe, 0);
    nextCycle();
    idleBus();

    // LW @0x1002 misaligned
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1002, 2'd2, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("lw_misalign", misalign, 1);
    checkOutput("lw_stall", stall, 0);
    checkOutput("lw_done", done, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("lw_dreq_valid", dreq_valid, 0);
    idleBus();
    @(negedge clk);
    checkOutput("lw_misalign_clear", misalign, 0);

    // LD @0x1008 flushed in WAIT, then LBU @0x1001
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1008, 2'd3, 1'b0, 64'h0);
    nextCycle();
    dresp_addr_ok = 1'b1;
    nextCycle();
    dresp_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("fl_wait_stall", stall, 1);
    checkOutput("fl_wait_done", done, 0);
    nextCycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fl_drain_stall", stall, 1);
    nextCycle();
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    checkOutput("fl_end_done", done, 0);
    checkOutput("fl_end_rdata", rdata, 0);
    checkOutput("fl_end_stall", stall, 0);
    nextCycle();
    dresp_data_ok = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1001, 2'd0, 1'b1, 64'h0);
    dresp_data = 64'h0000_0000_0000_AB00;
    @(negedge clk);
    checkOutput("lbu_c0_stall", stall, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("lbu_dreq_valid", dreq_valid, 1);
    checkOutput("lbu_addr", dreq_addr, 64'h1001);
    nextCycle();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    checkOutput("lbu_done", done, 1);
    checkOutput("lbu_rdata", rdata, 64'hAB);
    nextCycle();
    idleBus();

    // SD @0x1010 aborted by reset while in REQ
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h1010, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
    nextCycle();
    @(negedge clk);
    checkOutput("sd_dreq_valid", dreq_valid, 1);
    checkOutput("sd_strobe", dreq_strobe, 8'hFF);
    checkOutput("sd_data", dreq_data, 64'h0123_4567_89AB_CDEF);
    checkOutput("sd_size", dreq_size, 2'd3);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    idleBus();
    @(negedge clk);
    checkOutput("rstreq_dreq_valid", dreq_valid, 0);
    checkOutput("rstreq_strobe", dreq_strobe, 0);
    checkOutput("rstreq_stall", stall, 0);

    // LD @0x1000: legal on 64-bit bus, rejected on 32-bit bus; then flushed in REQ
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h1000, 2'd3, 1'b0, 64'h0);
    @(negedge clk);
    checkOutput("ld32_misalign", n_misalign, 1);
    checkOutput("ld32_stall", n_stall, 0);
    checkOutput("ld64_misalign", misalign, 0);
    checkOutput("ld64_stall", stall, 1);
    nextCycle();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flreq_dreq_valid", dreq_valid, 1);
    checkOutput("flreq_stall", stall, 0);
    checkOutput("flreq_done", done, 0);
    nextCycle();
    idleBus();
    @(negedge clk);
    checkOutput("flreq_after_valid", dreq_valid, 0);

    // SB 0x5A @0x1007
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h1007, 2'd0, 1'b0, 64'h5A);
    nextCycle();
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    checkOutput("sb_strobe", dreq_strobe, 8'h80);
    checkOutput("sb_data", dreq_data, 64'h5A00_0000_0000_0000);
    checkOutput("sb_done", done, 1);
    checkOutput("sb_rdata", rdata, 0);
    nextCycle();
    idleBus();
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
